// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the cache and memory: writes are queued and acked at once, then drained in order.
// Latency: write ack 1 cycle after accept; a forwarded read hit returns 1 cycle after accept (WB_FWD_EN).
// Backpressure: cache_req_ready drops when the FIFO is full or a read is pending; one memory op in flight.
// Optional feature macro: WB_FWD_EN enables read forwarding from queued writes and lets missing reads bypass.
module mem_write_buffer #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cache_req_valid,
  output logic                     cache_req_ready,
  input  logic                     cache_req_rw,
  input  logic [ADDR_W-1:0]        cache_req_addr,
  input  logic [LINE_W-1:0]        cache_req_wdata,
  output logic                     cache_resp_valid,
  output logic [LINE_W-1:0]        cache_resp_rdata,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_rw,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [LINE_W-1:0]        mem_req_wdata,
  input  logic                     mem_resp_valid,
  input  logic [LINE_W-1:0]        mem_resp_rdata,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_REQ  = 2'd1,
    M_WAIT = 2'd2
  } mstate_t;

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] ent_addr_q [DEPTH];
  logic [ADDR_W-1:0] ent_addr_d [DEPTH];
  logic [LINE_W-1:0] ent_data_q [DEPTH];
  logic [LINE_W-1:0] ent_data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Pending read and memory job
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  mstate_t           state_q, state_d;
  logic              job_rw_q, job_rw_d;
  logic [ADDR_W-1:0] job_addr_q, job_addr_d;
  logic [LINE_W-1:0] job_data_q, job_data_d;

  // Cache response register
  logic              resp_vld_q, resp_vld_d;
  logic [LINE_W-1:0] resp_dat_q, resp_dat_d;

  // Holds ready low for the first cycle after reset so every output reads 0 while in reset
  logic              ready_en_q, ready_en_d;

  logic full, empty, accept, push, pop, acc_rd;
  logic fwd_hit;
  logic [LINE_W-1:0] fwd_dat;
  logic rd_eligible;

  assign full            = (count_q == CNT_W'(DEPTH));
  assign empty           = (count_q == '0);
  assign cache_req_ready = ready_en_q && !full && !rd_pend_q;
  assign accept          = cache_req_valid && cache_req_ready;
  assign push            = accept && cache_req_rw;
  assign acc_rd          = accept && !cache_req_rw;
  assign pop             = (state_q == M_WAIT) && mem_resp_valid && job_rw_q;

`ifdef WB_FWD_EN
  // Search valid entries oldest to youngest so the youngest matching write wins
  always_comb begin
    fwd_hit = 1'b0;
    fwd_dat = '0;
    for (int k = 0; k < DEPTH; k++) begin : g_search
      logic [PTR_W-1:0] idx;
      idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (ent_addr_q[idx] == cache_req_addr)) begin
        fwd_hit = 1'b1;
        fwd_dat = ent_data_q[idx];
      end
    end
  end
  // A pending read only exists on a miss, so it may overtake queued writes
  assign rd_eligible = rd_pend_q;
`else
  // Without forwarding every read waits for the buffer to drain completely
  assign fwd_hit     = 1'b0;
  assign fwd_dat     = '0;
  assign rd_eligible = rd_pend_q && empty;
`endif

  // Next-state: FIFO push/pop, read capture, response generation and the memory FSM
  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_pend_d  = rd_pend_q;
    rd_addr_d  = rd_addr_q;
    state_d    = state_q;
    job_rw_d   = job_rw_q;
    job_addr_d = job_addr_q;
    job_data_d = job_data_q;
    resp_vld_d = 1'b0;
    resp_dat_d = '0;
    ready_en_d = 1'b1;

    if (push) begin
      ent_addr_d[wr_ptr_q] = cache_req_addr;
      ent_data_d[wr_ptr_q] = cache_req_wdata;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      resp_vld_d           = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (acc_rd) begin
      if (fwd_hit) begin
        resp_vld_d = 1'b1;
        resp_dat_d = fwd_dat;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = cache_req_addr;
      end
    end

    case (state_q)
      M_IDLE: begin
        if (rd_eligible) begin
          job_rw_d   = 1'b0;
          job_addr_d = rd_addr_q;
          job_data_d = '0;
          state_d    = M_REQ;
        end else if (!empty) begin
          job_rw_d   = 1'b1;
          job_addr_d = ent_addr_q[rd_ptr_q];
          job_data_d = ent_data_q[rd_ptr_q];
          state_d    = M_REQ;
        end
      end
      M_REQ: begin
        if (mem_req_ready) begin
          state_d = M_WAIT;
        end
      end
      M_WAIT: begin
        if (mem_resp_valid) begin
          state_d = M_IDLE;
          if (!job_rw_q) begin
            resp_vld_d = 1'b1;
            resp_dat_d = mem_resp_rdata;
            rd_pend_d  = 1'b0;
          end
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      state_q    <= M_IDLE;
      job_rw_q   <= 1'b0;
      job_addr_q <= '0;
      job_data_q <= '0;
      resp_vld_q <= 1'b0;
      resp_dat_q <= '0;
      ready_en_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      state_q    <= state_d;
      job_rw_q   <= job_rw_d;
      job_addr_q <= job_addr_d;
      job_data_q <= job_data_d;
      resp_vld_q <= resp_vld_d;
      resp_dat_q <= resp_dat_d;
      ready_en_q <= ready_en_d;
    end
  end

  // Entry storage needs no reset: only entries covered by count are ever read
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end

  assign cache_resp_valid = resp_vld_q;
  assign cache_resp_rdata = resp_dat_q;
  assign mem_req_valid    = (state_q == M_REQ);
  assign mem_req_rw       = job_rw_q;
  assign mem_req_addr     = job_addr_q;
  assign mem_req_wdata    = job_data_q;
  assign buf_count        = count_q;

endmodule

// File: tb/tb_mem_write_buffer.sv
module tb_mem_write_buffer;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int DP = 4;

  localparam logic [LW-1:0] DAT_A = 128'hA0A0_0000_0000_0000_0000_0000_0000_000A;
  localparam logic [LW-1:0] DAT_B = 128'hB0B0_1111_0000_0000_0000_0000_0000_000B;
  localparam logic [LW-1:0] DAT_C = 128'hC0C0_2222_0000_0000_0000_0000_0000_000C;
  localparam logic [LW-1:0] DAT_D = 128'hD0D0_3333_0000_0000_0000_0000_0000_000D;
  localparam logic [LW-1:0] DAT_E = 128'hE0E0_4444_0000_0000_0000_0000_0000_000E;
  localparam logic [LW-1:0] D1    = 128'h1111_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [LW-1:0] D2    = 128'h2222_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [LW-1:0] D3    = 128'h3333_0000_0000_0000_0000_0000_0000_0003;

  logic                 clk;
  logic                 rst;
  logic                 cache_req_valid;
  logic                 cache_req_ready;
  logic                 cache_req_rw;
  logic [AW-1:0]        cache_req_addr;
  logic [LW-1:0]        cache_req_wdata;
  logic                 cache_resp_valid;
  logic [LW-1:0]        cache_resp_rdata;
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic                 mem_req_rw;
  logic [AW-1:0]        mem_req_addr;
  logic [LW-1:0]        mem_req_wdata;
  logic                 mem_resp_valid;
  logic [LW-1:0]        mem_resp_rdata;
  logic [$clog2(DP):0]  buf_count;

  mem_write_buffer #(.ADDR_W(AW), .LINE_W(LW), .DEPTH(DP)) dut (
    .clk              (clk),
    .rst              (rst),
    .cache_req_valid  (cache_req_valid),
    .cache_req_ready  (cache_req_ready),
    .cache_req_rw     (cache_req_rw),
    .cache_req_addr   (cache_req_addr),
    .cache_req_wdata  (cache_req_wdata),
    .cache_resp_valid (cache_resp_valid),
    .cache_resp_rdata (cache_resp_rdata),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_rw       (mem_req_rw),
    .mem_req_addr     (mem_req_addr),
    .mem_req_wdata    (mem_req_wdata),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_rdata   (mem_resp_rdata),
    .buf_count        (buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: one request at a time, fixed latency, log of every accepted request
  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
    int            cyc;
  } mlog_t;

  mlog_t         mlog[$];
  logic [LW-1:0] mem_store [logic [AW-1:0]];
  bit            mem_ready_en = 1'b1;
  int            mem_lat = 2;
  bit            m_busy = 1'b0;
  int            m_cnt = 0;
  logic [LW-1:0] m_rdata = '0;

  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      if (!rst) begin
        m_busy = 1'b0;
        m_cnt  = 0;
        mem_store.delete();
      end else if (m_busy) begin
        m_cnt = m_cnt - 1;
        if (m_cnt <= 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = m_rdata;
          m_busy         = 1'b0;
        end
      end else if (mem_req_valid && mem_ready_en) begin
        mlog_t e;
        mem_req_ready = 1'b1;
        e.rw   = mem_req_rw;
        e.addr = mem_req_addr;
        e.data = mem_req_wdata;
        e.cyc  = cyc;
        mlog.push_back(e);
        if (mem_req_rw) begin
          mem_store[mem_req_addr] = mem_req_wdata;
          m_rdata = '0;
        end else begin
          m_rdata = mem_store.exists(mem_req_addr) ? mem_store[mem_req_addr] : '0;
        end
        m_busy = 1'b1;
        m_cnt  = mem_lat;
      end
    end
  end

  // Response monitor
  logic [LW-1:0] rq_dat[$];
  int            rq_cyc[$];
  always @(negedge clk) begin
    if (rst && cache_resp_valid) begin
      rq_dat.push_back(cache_resp_rdata);
      rq_cyc.push_back(cyc);
    end
  end

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic mlog_t get_log(input int i);
    mlog_t e;
    e = '{rw: 1'b0, addr: '0, data: '0, cyc: -1};
    if (i < mlog.size()) e = mlog[i];
    return e;
  endfunction

  // Present one request and hold it until accepted; returns the accept cycle
  task automatic send(input logic rw, input logic [AW-1:0] a, input logic [LW-1:0] d,
                      input string name, output int acc);
    cache_req_valid = 1'b1;
    cache_req_rw    = rw;
    cache_req_addr  = a;
    cache_req_wdata = d;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      if (cache_req_ready) begin
        acc = cyc;
        break;
      end
      nstep();
    end
    check({name, "_accepted"}, (acc >= 0), 1'b1);
    if (acc >= 0) nstep();
    cache_req_valid = 1'b0;
    cache_req_rw    = 1'b0;
    cache_req_addr  = '0;
    cache_req_wdata = '0;
  endtask

  task automatic get_resp(input string name, output logic [LW-1:0] dat, output int rc);
    rc  = -1;
    dat = '0;
    for (int i = 0; i < 300; i++) begin
      if (rq_dat.size() > 0) begin
        dat = rq_dat.pop_front();
        rc  = rq_cyc.pop_front();
        break;
      end
      nstep();
    end
    check({name, "_resp_seen"}, (rc >= 0), 1'b1);
  endtask

  task automatic wait_count(input int n, input string name);
    for (int i = 0; i < 300; i++) begin
      if (buf_count == n) break;
      nstep();
    end
    check(name, buf_count, n);
  endtask

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            acc, acc2, rc;
    logic [LW-1:0] dat;
    mlog_t         e;

    vecs[0] = '{1'b1, 32'h100, D1, '0};
    vecs[1] = '{1'b1, 32'h101, D2, '0};
    vecs[2] = '{1'b0, 32'h100, '0, D1};
    vecs[3] = '{1'b1, 32'h100, D3, '0};
    vecs[4] = '{1'b0, 32'h100, '0, D3};
    vecs[5] = '{1'b0, 32'h101, '0, D2};
    vecs[6] = '{1'b0, 32'h200, '0, '0};

    rst             = 1'b0;
    cache_req_valid = 1'b0;
    cache_req_rw    = 1'b0;
    cache_req_addr  = '0;
    cache_req_wdata = '0;
    repeat (3) nstep();

    // Reset state
    check("rst_req_ready",   cache_req_ready,  1'b0);
    check("rst_resp_valid",  cache_resp_valid, 1'b0);
    check("rst_resp_rdata",  cache_resp_rdata, '0);
    check("rst_mem_valid",   mem_req_valid,    1'b0);
    check("rst_mem_addr",    mem_req_addr,     '0);
    check("rst_buf_count",   buf_count,        '0);
    rst = 1'b1;
    nstep();
    nstep();
    check("post_rst_ready",  cache_req_ready,  1'b1);

    // T1: single write, ack next cycle, drains to memory
    send(1'b1, 32'h10, DAT_A, "t1", acc);
    check("t1_count_after_push", buf_count, 1);
    get_resp("t1", dat, rc);
    check("t1_ack_cycle", rc, acc + 1);
    check("t1_ack_data",  dat, '0);
    wait_count(0, "t1_drained");
    e = get_log(0);
    check("t1_mem_ops",  mlog.size(), 1);
    check("t1_mem_rw",   e.rw,   1'b1);
    check("t1_mem_addr", e.addr, 32'h10);
    check("t1_mem_data", e.data, DAT_A);
    mlog.delete();

    // Table of write/read transactions; reads must see the latest written value
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].rw, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i), acc);
      get_resp($sformatf("vec%0d", i), dat, rc);
      check($sformatf("vec%0d_rdata", i), dat, vecs[i].exp);
      if (vecs[i].rw) check($sformatf("vec%0d_ack_cycle", i), rc, acc + 1);
    end
    wait_count(0, "vec_drained");
    mlog.delete();

    // T2: fill the buffer with memory stalled, then release
    mem_ready_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 32'h80 + k, DAT_A + LW'(k), $sformatf("t2_w%0d", k), acc);
      get_resp($sformatf("t2_w%0d", k), dat, rc);
      check($sformatf("t2_w%0d_ack", k), rc, acc + 1);
    end
    check("t2_full_count", buf_count, 4);
    check("t2_full_ready", cache_req_ready, 1'b0);
    cache_req_valid = 1'b1;
    cache_req_rw    = 1'b1;
    repeat (3) nstep();
    check("t2_stall_ready", cache_req_ready, 1'b0);
    check("t2_stall_count", buf_count, 4);
    mem_ready_en = 1'b1;
    send(1'b1, 32'h84, DAT_A + LW'(4), "t2_w4", acc);
    get_resp("t2_w4", dat, rc);
    e = get_log(0);
    check("t2_5th_after_pop", (acc > e.cyc + mem_lat), 1'b1);
    wait_count(0, "t2_drained");
    check("t2_mem_ops", mlog.size(), 5);
    for (int k = 0; k < 5; k++) begin
      e = get_log(k);
      check($sformatf("t2_order%0d_addr", k), e.addr, 32'h80 + k);
      check($sformatf("t2_order%0d_data", k), e.data, DAT_A + LW'(k));
    end
    mlog.delete();

`ifndef WB_FWD_EN
    // T3: read after write to the same line waits for the drain
    send(1'b1, 32'h20, DAT_B, "t3_w", acc);
    send(1'b0, 32'h20, '0, "t3_r", acc2);
    check("t3_read_accept_cycle", acc2, acc + 1);
    check("t3_ready_while_pend", cache_req_ready, 1'b0);
    get_resp("t3_w", dat, rc);
    check("t3_ack_data", dat, '0);
    get_resp("t3_r", dat, rc);
    check("t3_read_data", dat, DAT_B);
    check("t3_mem_ops", mlog.size(), 2);
    e = get_log(0);
    check("t3_first_is_write", e.rw, 1'b1);
    acc = e.cyc;
    e = get_log(1);
    check("t3_second_is_read", e.rw, 1'b0);
    check("t3_read_addr", e.addr, 32'h20);
    check("t3_read_after_ack", (e.cyc > acc + mem_lat), 1'b1);
    wait_count(0, "t3_drained");
    mlog.delete();
`else
    // T4: forwarding returns the youngest matching write, no memory read
    mem_ready_en = 1'b0;
    send(1'b1, 32'h30, DAT_C, "t4_w0", acc);
    send(1'b1, 32'h30, DAT_D, "t4_w1", acc);
    get_resp("t4_w0", dat, rc);
    get_resp("t4_w1", dat, rc);
    send(1'b0, 32'h30, '0, "t4_r", acc);
    get_resp("t4_r", dat, rc);
    check("t4_fwd_cycle", rc, acc + 1);
    check("t4_fwd_data", dat, DAT_D);
    mem_ready_en = 1'b1;
    wait_count(0, "t4_drained");
    check("t4_mem_ops", mlog.size(), 2);
    e = get_log(0);
    check("t4_op0_write", e.rw, 1'b1);
    e = get_log(1);
    check("t4_op1_write", e.rw, 1'b1);
    check("t4_op1_data", e.data, DAT_D);
    mlog.delete();

    // T5: a missing read overtakes a queued (not yet started) write
    mem_ready_en = 1'b0;
    send(1'b1, 32'h3F, DAT_C, "t5_w0", acc);
    send(1'b1, 32'h40, DAT_E, "t5_w1", acc);
    get_resp("t5_w0", dat, rc);
    get_resp("t5_w1", dat, rc);
    send(1'b0, 32'h50, '0, "t5_r", acc);
    mem_ready_en = 1'b1;
    get_resp("t5_r", dat, rc);
    check("t5_read_data", dat, '0);
    wait_count(0, "t5_drained");
    check("t5_mem_ops", mlog.size(), 3);
    e = get_log(0);
    check("t5_op0_addr", e.addr, 32'h3F);
    e = get_log(1);
    check("t5_op1_read", e.rw, 1'b0);
    check("t5_op1_addr", e.addr, 32'h50);
    e = get_log(2);
    check("t5_op2_addr", e.addr, 32'h40);
    mlog.delete();
`endif

    // T6: reset while a write is in flight with three entries queued
    mem_lat = 20;
    send(1'b1, 32'h58, DAT_A, "t6_w0", acc);
    send(1'b1, 32'h59, DAT_B, "t6_w1", acc);
    send(1'b1, 32'h5A, DAT_C, "t6_w2", acc);
    nstep();
    nstep();
    check("t6_count_before", buf_count, 3);
    check("t6_in_wait", mem_req_valid, 1'b0);
    rst = 1'b0;
    #1;
    check("t6_rst_count",      buf_count,        '0);
    check("t6_rst_ready",      cache_req_ready,  1'b0);
    check("t6_rst_resp_valid", cache_resp_valid, 1'b0);
    check("t6_rst_mem_valid",  mem_req_valid,    1'b0);
    check("t6_rst_mem_rw",     mem_req_rw,       1'b0);
    check("t6_rst_mem_addr",   mem_req_addr,     '0);
    check("t6_rst_mem_wdata",  mem_req_wdata,    '0);
    nstep();
    nstep();
    mlog.delete();
    rq_dat.delete();
    rq_cyc.delete();
    mem_lat = 2;
    rst = 1'b1;
    nstep();
    nstep();
    send(1'b1, 32'h60, DAT_E, "t6_w_new", acc);
    get_resp("t6_w_new", dat, rc);
    check("t6_new_ack_cycle", rc, acc + 1);
    wait_count(0, "t6_drained");
    check("t6_mem_ops", mlog.size(), 1);
    e = get_log(0);
    check("t6_mem_addr", e.addr, 32'h60);
    check("t6_mem_data", e.data, DAT_E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
